// File: rtl/led_bar_pkg.sv
// rtl/led_bar_pkg.sv - shared types and thermometer encoder for the LED bar controller
//
// Purpose: command, display-mode and FSM state encodings plus the
// level-to-bar thermometer function used by led_bar_ctrl.
// Ports: none (package).

package led_bar_pkg;

  typedef enum logic [1:0] {
    OP_SET_LEVEL = 2'b00,
    OP_SET_MODE  = 2'b01,
    OP_ALARM_ON  = 2'b10,
    OP_ALARM_OFF = 2'b11
  } cmd_op_e;

  typedef enum logic {
    STEADY = 1'b0,
    BLINK  = 1'b1
  } mode_e;

  typedef enum logic {
    NORMAL = 1'b0,
    ALARM  = 1'b1
  } state_e;

  // Widest bar the encoder can produce; callers size-cast down to N_LED.
  localparam int unsigned THERMO_MAX = 32;

  // Lowest lvl bits set, e.g. lvl=3 -> ...0111.
  function automatic logic [THERMO_MAX-1:0] thermo(input int unsigned lvl);
    if (lvl >= THERMO_MAX) begin
      return '1;
    end
    return (32'd1 << lvl) - 32'd1;
  endfunction

endpackage

// File: rtl/led_bar_ctrl_divider.sv
// rtl/led_bar_ctrl_divider.sv - free-running blink timebase for the LED bar controller
//
// Purpose: counts 0..BLINK_HALF-1 forever and toggles the blink phase on wrap.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   tick  out  combinational, high in the cycle whose closing edge wraps the counter
//   phase out  registered blink phase, toggles on the wrapping edge

module blink_divider #(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic phase
);

  localparam int unsigned CW = $clog2(BLINK_HALF);

  logic [CW-1:0] cnt_q;

  // Combinational so the top can fold the upcoming phase into its
  // output register on the same edge the phase itself toggles.
  assign tick = (cnt_q == CW'(BLINK_HALF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      phase <= ~phase;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_bar_ctrl.sv
// rtl/led_bar_ctrl.sv - LED bar-graph and alarm indicator for the lock panel
//
// Purpose: latches level/mode from single-cycle commands, drives a thermometer
// bar (steady or blinking) and an alarm state that flashes all LEDs and clears
// on command or after ALARM_TICKS blink half-periods.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   cmd_valid   in   command strobe
//   cmd_op      in   [1:0] opcode (SET_LEVEL, SET_MODE, ALARM_ON, ALARM_OFF)
//   cmd_arg     in   [LW-1:0] level, or bit 0 = blink enable
//   led         out  [N_LED-1:0] registered bar output
//   alarm       out  registered alarm flag
//   blink_phase out  registered blink phase

module led_bar_ctrl
  import led_bar_pkg::*;
#(
  parameter int unsigned N_LED       = 4,
  parameter int unsigned BLINK_HALF  = 25_000_000,
  parameter int unsigned ALARM_TICKS = 20,
  localparam int unsigned LW         = $clog2(N_LED + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [LW-1:0]    cmd_arg,
  output logic [N_LED-1:0] led,
  output logic             alarm,
  output logic             blink_phase
);

  // Counter only needs to reach ALARM_TICKS-1: the tick that would take it
  // to ALARM_TICKS is the exit edge itself.
  localparam int unsigned TW      = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam int unsigned TO_LAST = (ALARM_TICKS > 0) ? ALARM_TICKS - 1 : 0;

  logic             tick;
  logic             phase_q;
  logic             phase_d;
  cmd_op_e          op;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [LW-1:0]    level_q, level_d;
  logic [TW-1:0]    to_q, to_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             alarm_q, alarm_d;
  logic [N_LED-1:0] bar;

  blink_divider #(
    .BLINK_HALF(BLINK_HALF)
  ) u_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .phase(phase_q)
  );

  // Phase value that will be visible after this edge; led follows it with no lag.
  assign phase_d = phase_q ^ tick;
  assign op      = cmd_op_e'(cmd_op);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      mode_q  <= STEADY;
      level_q <= '0;
      to_q    <= '0;
      led_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      to_q    <= to_d;
      led_q   <= led_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    level_d = level_q;
    to_d    = to_q;
    bar     = '0;
    alarm_d = 1'b0;
    led_d   = '0;

    // Timeout is evaluated first so a same-cycle command overrides it:
    // ALARM_ON restarts the count, ALARM_OFF exits either way.
    if (state_q == ALARM && tick) begin
      if (ALARM_TICKS != 0 && to_q == TW'(TO_LAST)) begin
        state_d = NORMAL;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    if (cmd_valid) begin
      case (op)
        OP_SET_LEVEL: level_d = (cmd_arg > LW'(N_LED)) ? LW'(N_LED) : cmd_arg;
        OP_SET_MODE:  mode_d  = cmd_arg[0] ? BLINK : STEADY;
        OP_ALARM_ON: begin
          state_d = ALARM;
          to_d    = '0;
        end
        OP_ALARM_OFF: state_d = NORMAL;
        default: ;
      endcase
    end

    // Outputs are built from next-state values so a level change landing on
    // the alarm-exit edge is shown immediately.
    bar     = N_LED'(thermo(32'(level_d)));
    alarm_d = (state_d == ALARM);
    if (alarm_d) begin
      led_d = {N_LED{phase_d}};
    end else if (mode_d == BLINK) begin
      led_d = bar & {N_LED{phase_d}};
    end else begin
      led_d = bar;
    end
  end

  assign led         = led_q;
  assign alarm       = alarm_q;
  assign blink_phase = phase_q;

endmodule
